// File: rtl/pc_npc_fetch_sequencer_if.sv
// Instruction-memory request/acknowledge port of the PC/nPC fetch sequencer.
// The sequencer is the master: it raises a request with an address and holds
// both until the memory answers with an acknowledge and the data word.
interface pc_npc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/pc_npc_fetch_sequencer.sv
// SPARC-style PC/nPC fetch sequencer.
// Keeps the architectural PC/nPC pair, fetches the word at PC over the
// request/acknowledge port and presents it as IR31_0 to the downstream
// shifter/sign-extender. On Advance the pair moves forward with nPC taken
// from nPC+4, PC+Disp, the ALU target or the trap base. A delayed-branch
// annul squashes the delay-slot word: it is fetched but never made valid.
module pc_npc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_BASE = 32'h0000_0080
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_srst,
  input  logic [31:0]                    i_disp,
  input  logic [31:0]                    i_target,
  input  logic [1:0]                     i_next_sel,
  input  logic                           i_annul,
  input  logic                           i_advance,
  pc_npc_fetch_sequencer_if.master       mem,
  output logic [31:0]                    o_ir31_0,
  output logic                           o_ir_valid,
  output logic [31:0]                    o_pc,
  output logic [31:0]                    o_npc,
  output logic                           o_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_REL    = 2'b01;
  localparam logic [1:0] SEL_TARGET = 2'b10;
  localparam logic [1:0] SEL_TRAP   = 2'b11;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic        r_req;
  logic        r_misalign;
  logic        r_annul;

  logic [31:0] w_npc_inc;
  logic [31:0] w_npc_next;
  logic        w_misalign;

  // Select the nPC that an Advance would load, and flag a misaligned jump target.
  always_comb begin
    w_npc_inc  = r_npc + 32'd4;
    w_npc_next = w_npc_inc;
    w_misalign = 1'b0;
    case (i_next_sel)
      SEL_SEQ: begin
        w_npc_next = w_npc_inc;
      end
      SEL_REL: begin
        // relative to the branch itself, i.e. the PC before the update
        w_npc_next = r_pc + i_disp;
      end
      SEL_TARGET: begin
        w_npc_next = {i_target[31:2], 2'b00};
        w_misalign = (i_target[1:0] != 2'b00);
      end
      SEL_TRAP: begin
        w_npc_next = TRAP_BASE;
      end
      default: begin
        w_npc_next = w_npc_inc;
      end
    endcase
  end

  // Fetch FSM: owns the PC/nPC pair, the IR, the request line and the misalign pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_npc      <= RESET_PC + 32'd4;
      r_ir       <= 32'h0000_0000;
      r_ir_valid <= 1'b0;
      r_req      <= 1'b0;
      r_misalign <= 1'b0;
      r_annul    <= 1'b0;
    end else if (i_srst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_npc      <= RESET_PC + 32'd4;
      r_ir       <= 32'h0000_0000;
      r_ir_valid <= 1'b0;
      r_req      <= 1'b0;
      r_misalign <= 1'b0;
      r_annul    <= 1'b0;
    end else begin
      // misalign is a single-cycle pulse unless re-armed by a jump below
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // one dead cycle after reset, then start fetching at PC
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem.imem_ack) begin
            if (r_annul) begin
              // squashed delay slot: drop the word and fetch the next one at once
              r_pc    <= r_npc;
              r_npc   <= w_npc_inc;
              r_annul <= 1'b0;
              r_req   <= 1'b1;
            end else begin
              r_ir       <= mem.imem_data;
              r_ir_valid <= 1'b1;
              r_req      <= 1'b0;
              r_state    <= ST_VALID;
            end
          end else begin
            // keep request and address steady while memory waits
            r_req <= 1'b1;
          end
        end
        ST_VALID: begin
          if (i_advance) begin
            r_pc       <= r_npc;
            r_npc      <= w_npc_next;
            r_annul    <= i_annul;
            r_ir_valid <= 1'b0;
            r_req      <= 1'b1;
            r_misalign <= w_misalign;
            r_state    <= ST_FETCH;
          end else begin
            r_req <= 1'b0;
          end
        end
        default: begin
          // unreachable encoding: recover through a clean restart
          r_state    <= ST_IDLE;
          r_ir_valid <= 1'b0;
          r_req      <= 1'b0;
          r_annul    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.imem_req  = r_req;
  assign mem.imem_addr = r_pc;
  assign o_ir31_0      = r_ir;
  assign o_ir_valid    = r_ir_valid;
  assign o_pc          = r_pc;
  assign o_npc         = r_npc;
  assign o_misalign    = r_misalign;

endmodule
